sense_debounce: RTL and testbench
=================================

# sense_debounce

Multi-channel, parametrised successor to the keypad hold counter. Each of CHANNELS sense lines gets an optional input synchroniser and a saturating up/down integrator with hysteresis. The block produces a debounced level, press/release pulses, and aggregate any-pressed and all-released flags. It sits between the keypad column pins and the scan FSM, which gates it with enable while waiting on a row.

## Interface
- CHANNELS, 4: number of sense lines.
- HOLD_TOP, 16: integrator saturation ceiling; must be ≥ 2.
- CNT_W, 16: counter width; must satisfy 2^CNT_W > HOLD_TOP (elaboration-time check, fatal).
- SYNC_STAGES, 2: synchroniser flops per channel, 0–3; 0 means sense feeds the integrator directly.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low.
- enable  input  1  run request from scan FSM.
- sense  input  CHANNELS  raw, asynchronous, active-high key lines.
- level  output  CHANNELS  registered debounced state per channel.
- press  output  CHANNELS  one-cycle pulse on level 0→1.
- release  output  CHANNELS  one-cycle pulse on level 1→0.
- anyPressed  output  1  enable & |level (combinational).
- allReleased  output  1  enable & every counter == 0 (combinational).

## Operation
- MID = HOLD_TOP/2, integer division.
- Shared control FSM with states OFF, BOOT, RUN:
  - OFF→BOOT when enable = 1; otherwise stay in OFF.
  - BOOT→RUN unconditionally.
  - RUN→OFF when enable = 0; otherwise stay in RUN.
  - Illegal encodings go to OFF.
- Reset (reset = 0 at an edge):
  - state = OFF, all counters = MID, level/press/release = 0, synchroniser flops = 0.
  - Reset overrides every other action.
- OFF or BOOT:
  - Counters load MID; level, press and release are 0.
  - The synchroniser keeps sampling so that RUN sees fresh data.
- RUN, per channel, with s = synchronised sense bit:
  - s = 1 and counter < HOLD_TOP: counter + 1.
  - s = 0 and counter > 0: counter − 1.
  - Otherwise: hold. The counter never wraps.
- Level hysteresis, evaluated in RUN from the registered counter:
  - counter == HOLD_TOP: level ← 1.
  - counter == 0: level ← 0.
  - Otherwise: hold.
- Pulses:
  - press ← level_next & ~level; release ← ~level_next & level. Both are registered and asserted in the same cycle the new level first appears.
- Leaving RUN (enable low or reset) clears level without emitting a release pulse.
- Channels are fully independent. Simultaneous press and release on different channels in the same cycle is legal.

## Timing
- enable sampled high at edge E0: state = BOOT after E0, RUN after E1. The first count occurs at E2.
- Sense-to-counter latency: SYNC_STAGES edges for synchronisation, plus 1 edge to update the counter.
- Counter-to-level latency: 1 edge after the counter reaches HOLD_TOP or 0. press/release appear on that same edge.
- From MID with a constant input, level changes HOLD_TOP − MID + 1 edges after the first RUN count (rising), or MID + 1 edges (falling), excluding synchroniser latency.
- enable low sampled at edge Ek: after Ek the state is OFF and anyPressed = allReleased = 0 immediately (combinational gating). Counters read MID and level reads 0 after Ek+1.
- Re-asserting enable always restarts from BOOT with counters at MID. No history is retained.

## Test plan
- Reset release, enable = 0, sense = 4'hF for 20 cycles -> level = 0, press = 0, anyPressed = 0, allReleased = 0, counters = MID.
- HOLD_TOP = 8, SYNC_STAGES = 0, enable rises at E0, sense[0] = 1 held -> counter0 goes 4,5,6,7,8 after E2..E5. level[0] = 1 and a single press[0] pulse appear after E6. The counter stays at 8 thereafter.
- Same setup, sense[0] then drops to 0 -> counter decrements to 0 in 8 edges. release[0] pulses one edge later. allReleased = 1 once all four counters are 0.
- Bounce: sense[1] toggles every cycle for 40 cycles from MID -> counter stays in 3..5, level[1] stays 0, and no pulses occur.
- Mid-run enable drop with level[2] = 1 -> anyPressed falls the same cycle, level clears next edge, and no release pulse occurs. Re-enable -> counters restart at MID via BOOT.
- SYNC_STAGES = 2, single-cycle sense glitch and reset asserted mid-RUN -> the glitch shifts the counter by 1 only. Reset forces all outputs to 0 and counters to MID at the next edge.

Source files
------------

// File: rtl/sense_debounce_if.sv
// Sense-line bundle between the keypad pins/scan FSM and the debouncer.
// "release" is a reserved word, so the release pulse is named release_pulse.
interface sense_debounce_if #(
    parameter int CHANNELS = 4
);
    logic                enable;
    logic [CHANNELS-1:0] sense;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] press;
    logic [CHANNELS-1:0] release_pulse;
    logic                anyPressed;
    logic                allReleased;

    modport master (
        output enable, sense,
        input  level, press, release_pulse, anyPressed, allReleased
    );

    modport slave (
        input  enable, sense,
        output level, press, release_pulse, anyPressed, allReleased
    );
endinterface

// File: rtl/sense_debounce.sv
// Multi-channel key debouncer: optional synchroniser plus a saturating
// up/down integrator with hysteresis per channel, gated by a shared FSM.
module sense_debounce #(
    parameter int CHANNELS    = 4,
    parameter int HOLD_TOP    = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    sense_debounce_if.slave  bus
);

    localparam int MID = HOLD_TOP / 2;
    localparam logic [CNT_W-1:0] TOP_C = CNT_W'(HOLD_TOP);
    localparam logic [CNT_W-1:0] MID_C = CNT_W'(MID);

    if (HOLD_TOP < 2) begin : g_bad_top
        $fatal(1, "sense_debounce: HOLD_TOP must be >= 2");
    end
    if (CNT_W < 31 && (2 ** CNT_W) <= HOLD_TOP) begin : g_bad_w
        $fatal(1, "sense_debounce: CNT_W too narrow for HOLD_TOP");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
        $fatal(1, "sense_debounce: SYNC_STAGES must be 0..3");
    end

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        BOOT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                          state;
    logic [CHANNELS-1:0]             s;
    logic [CHANNELS-1:0][CNT_W-1:0]  count;
    logic [CHANNELS-1:0][CNT_W-1:0]  cnt_next;
    logic [CHANNELS-1:0]             level;
    logic [CHANNELS-1:0]             lvl_next;
    logic [CHANNELS-1:0]             press;
    logic [CHANNELS-1:0]             rel;
    logic                            all_zero;

    // The synchroniser runs in every state so RUN starts on fresh samples.
    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = bus.sense;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0][CHANNELS-1:0] pipe;

        always_ff @(posedge clk) begin
            if (!reset) begin
                pipe <= '0;
            end else begin
                pipe[0] <= bus.sense;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign s = pipe[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= OFF;
        end else begin
            case (state)
                OFF:     state <= bus.enable ? BOOT : OFF;
                BOOT:    state <= RUN;
                RUN:     state <= bus.enable ? RUN : OFF;
                default: state <= OFF;
            endcase
        end
    end

    always_comb begin
        cnt_next = count;
        lvl_next = level;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s[i] && count[i] < TOP_C) begin
                cnt_next[i] = count[i] + CNT_W'(1);
            end else if (!s[i] && count[i] != '0) begin
                cnt_next[i] = count[i] - CNT_W'(1);
            end
            if (count[i] == TOP_C) begin
                lvl_next[i] = 1'b1;
            end else if (count[i] == '0) begin
                lvl_next[i] = 1'b0;
            end
        end
    end

    // Outside RUN everything parks at MID/0, so leaving RUN drops level
    // without a release pulse and re-entry carries no history.
    always_ff @(posedge clk) begin
        if (!reset || state != RUN) begin
            count <= {CHANNELS{MID_C}};
            level <= '0;
            press <= '0;
            rel   <= '0;
        end else begin
            count <= cnt_next;
            level <= lvl_next;
            press <= lvl_next & ~level;
            rel   <= ~lvl_next & level;
        end
    end

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (count[i] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    assign bus.level         = level;
    assign bus.press         = press;
    assign bus.release_pulse = rel;
    assign bus.anyPressed    = bus.enable & (|level);
    assign bus.allReleased   = bus.enable & all_zero;

endmodule

// File: tb/tb_sense_debounce.sv
// Directed bench for sense_debounce: HOLD_TOP=8 with no synchroniser
// (dut0) and with a two-stage synchroniser (dut1).
module tb_sense_debounce;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sense_debounce_if #(.CHANNELS(4)) b0 ();
    sense_debounce_if #(.CHANNELS(4)) b1 ();

    sense_debounce #(
        .CHANNELS(4), .HOLD_TOP(8), .CNT_W(8), .SYNC_STAGES(0)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );

    sense_debounce #(
        .CHANNELS(4), .HOLD_TOP(8), .CNT_W(8), .SYNC_STAGES(2)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        b0.sense = 4'hF;
        b1.sense = 4'hF;
        repeat (20) step();
        checks++;
        if (b0.level !== 4'h0 || b1.level !== 4'h0) begin
            $display("FAIL reset_level got=%h/%h exp=0", b0.level, b1.level);
            failures++;
        end
        checks++;
        if (b0.press !== 4'h0 || b1.press !== 4'h0) begin
            $display("FAIL reset_press got=%h/%h exp=0", b0.press, b1.press);
            failures++;
        end
        checks++;
        if (b0.anyPressed !== 1'b0 || b1.anyPressed !== 1'b0) begin
            $display("FAIL reset_any got=%b/%b exp=0", b0.anyPressed, b1.anyPressed);
            failures++;
        end
        checks++;
        if (b0.allReleased !== 1'b0 || b1.allReleased !== 1'b0) begin
            $display("FAIL reset_allrel got=%b/%b exp=0", b0.allReleased, b1.allReleased);
            failures++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut0.count[i] !== 8'd4 || dut1.count[i] !== 8'd4) begin
                $display("FAIL reset_cnt ch=%0d got=%0d/%0d exp=4",
                         i, dut0.count[i], dut1.count[i]);
                failures++;
            end
        end
        b0.sense = 4'h0;
        b1.sense = 4'h0;
        step();
    endtask

    task automatic test_rise();
        logic [7:0] exp_c;
        b0.sense  = 4'b0001;
        b0.enable = 1'b1;
        step();
        checks++;
        if (dut0.count[0] !== 8'd4) begin
            $display("FAIL rise_boot_cnt got=%0d exp=4", dut0.count[0]);
            failures++;
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_c = (k < 2) ? 8'd4 : 8'(3 + k);
            checks++;
            if (dut0.count[0] !== exp_c || b0.level[0] !== 1'b0) begin
                $display("FAIL rise_cnt k=%0d got=%0d lvl=%b exp=%0d lvl=0",
                         k, dut0.count[0], b0.level[0], exp_c);
                failures++;
            end
        end
        step();
        checks++;
        if (b0.level !== 4'b0001 || b0.press !== 4'b0001) begin
            $display("FAIL rise_press got lvl=%b prs=%b exp lvl=0001 prs=0001",
                     b0.level, b0.press);
            failures++;
        end
        checks++;
        if (b0.anyPressed !== 1'b1 || b0.allReleased !== 1'b0) begin
            $display("FAIL rise_flags got any=%b all=%b exp any=1 all=0",
                     b0.anyPressed, b0.allReleased);
            failures++;
        end
        step();
        checks++;
        if (b0.press !== 4'b0 || b0.level[0] !== 1'b1 || dut0.count[0] !== 8'd8) begin
            $display("FAIL rise_hold got prs=%b lvl=%b cnt=%0d exp prs=0 lvl=1 cnt=8",
                     b0.press, b0.level[0], dut0.count[0]);
            failures++;
        end
    endtask

    task automatic test_fall();
        b0.sense = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (dut0.count[0] !== 8'(8 - k) || b0.level[0] !== 1'b1
                || b0.release_pulse !== 4'b0) begin
                $display("FAIL fall_cnt k=%0d got=%0d lvl=%b rel=%b exp=%0d lvl=1 rel=0",
                         k, dut0.count[0], b0.level[0], b0.release_pulse, 8 - k);
                failures++;
            end
        end
        checks++;
        if (b0.allReleased !== 1'b1) begin
            $display("FAIL fall_allrel got=%b exp=1", b0.allReleased);
            failures++;
        end
        step();
        checks++;
        if (b0.level !== 4'b0 || b0.release_pulse !== 4'b0001) begin
            $display("FAIL fall_release got lvl=%b rel=%b exp lvl=0000 rel=0001",
                     b0.level, b0.release_pulse);
            failures++;
        end
        step();
        checks++;
        if (b0.release_pulse !== 4'b0) begin
            $display("FAIL fall_rel_once got=%b exp=0000", b0.release_pulse);
            failures++;
        end
    endtask

    task automatic test_bounce();
        logic [3:0] v;
        int         lo;
        int         hi;
        logic       lvl_seen;
        logic       pulse_seen;
        b0.enable = 1'b0;
        step();
        step();
        b0.enable = 1'b1;
        step();
        step();
        checks++;
        if (dut0.count[1] !== 8'd4) begin
            $display("FAIL bounce_start got=%0d exp=4", dut0.count[1]);
            failures++;
        end
        lo = 255;
        hi = 0;
        lvl_seen = 1'b0;
        pulse_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            v = 4'b0;
            v[1] = (k % 2 == 0);
            b0.sense = v;
            step();
            if (int'(dut0.count[1]) < lo) lo = int'(dut0.count[1]);
            if (int'(dut0.count[1]) > hi) hi = int'(dut0.count[1]);
            if (b0.level[1] !== 1'b0) lvl_seen = 1'b1;
            if (b0.press !== 4'b0 || b0.release_pulse !== 4'b0) pulse_seen = 1'b1;
        end
        checks++;
        if (lo < 3 || hi > 5) begin
            $display("FAIL bounce_range got lo=%0d hi=%0d exp within 3..5", lo, hi);
            failures++;
        end
        checks++;
        if (lvl_seen !== 1'b0) begin
            $display("FAIL bounce_level got=1 exp=0");
            failures++;
        end
        checks++;
        if (pulse_seen !== 1'b0) begin
            $display("FAIL bounce_pulse got=1 exp=0");
            failures++;
        end
        b0.sense = 4'b0;
    endtask

    task automatic test_enable_drop();
        b0.sense = 4'b0100;
        repeat (12) step();
        checks++;
        if (b0.level[2] !== 1'b1 || b0.anyPressed !== 1'b1) begin
            $display("FAIL drop_pre got lvl=%b any=%b exp lvl=1 any=1",
                     b0.level[2], b0.anyPressed);
            failures++;
        end
        b0.enable = 1'b0;
        #1;
        checks++;
        if (b0.anyPressed !== 1'b0 || b0.allReleased !== 1'b0) begin
            $display("FAIL drop_comb got any=%b all=%b exp any=0 all=0",
                     b0.anyPressed, b0.allReleased);
            failures++;
        end
        step();
        checks++;
        if (b0.level[2] !== 1'b1 || b0.release_pulse !== 4'b0) begin
            $display("FAIL drop_ek got lvl=%b rel=%b exp lvl=1 rel=0000",
                     b0.level[2], b0.release_pulse);
            failures++;
        end
        step();
        checks++;
        if (b0.level !== 4'b0 || b0.release_pulse !== 4'b0 || dut0.count[2] !== 8'd4) begin
            $display("FAIL drop_ek1 got lvl=%b rel=%b cnt=%0d exp lvl=0 rel=0 cnt=4",
                     b0.level, b0.release_pulse, dut0.count[2]);
            failures++;
        end
        b0.enable = 1'b1;
        step();
        step();
        checks++;
        if (dut0.count[2] !== 8'd4 || b0.level !== 4'b0) begin
            $display("FAIL reen_boot got cnt=%0d lvl=%b exp cnt=4 lvl=0",
                     dut0.count[2], b0.level);
            failures++;
        end
        step();
        checks++;
        if (dut0.count[2] !== 8'd5) begin
            $display("FAIL reen_first got=%0d exp=5", dut0.count[2]);
            failures++;
        end
        b0.sense = 4'b0;
    endtask

    task automatic test_sync_glitch();
        logic [7:0] exp_g [4];
        exp_g[0] = 8'd0;
        exp_g[1] = 8'd0;
        exp_g[2] = 8'd1;
        exp_g[3] = 8'd0;
        b1.sense  = 4'b0;
        b1.enable = 1'b1;
        repeat (8) step();
        checks++;
        if (dut1.count[0] !== 8'd0) begin
            $display("FAIL glitch_floor got=%0d exp=0", dut1.count[0]);
            failures++;
        end
        b1.sense = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step();
            b1.sense = 4'b0;
            checks++;
            if (dut1.count[0] !== exp_g[k] || b1.level[0] !== 1'b0 || b1.press !== 4'b0) begin
                $display("FAIL glitch_cnt k=%0d got=%0d lvl=%b prs=%b exp=%0d lvl=0 prs=0",
                         k, dut1.count[0], b1.level[0], b1.press, exp_g[k]);
                failures++;
            end
        end
    endtask

    task automatic test_reset_mid_run();
        b1.sense = 4'hF;
        repeat (14) step();
        checks++;
        if (b1.level !== 4'hF) begin
            $display("FAIL rstrun_pre got=%b exp=1111", b1.level);
            failures++;
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (b1.level !== 4'h0 || b1.press !== 4'h0 || b1.release_pulse !== 4'h0
            || b1.anyPressed !== 1'b0) begin
            $display("FAIL rstrun_out got lvl=%b prs=%b rel=%b any=%b exp all 0",
                     b1.level, b1.press, b1.release_pulse, b1.anyPressed);
            failures++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut1.count[i] !== 8'd4) begin
                $display("FAIL rstrun_cnt ch=%0d got=%0d exp=4", i, dut1.count[i]);
                failures++;
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        b0.enable = 1'b0;
        b0.sense  = 4'b0;
        b1.enable = 1'b0;
        b1.sense  = 4'b0;
        test_reset();
        test_rise();
        test_fall();
        test_bounce();
        test_enable_drop();
        test_sync_glitch();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
